reg_file_wb: RTL

- Architectural register file for the single-issue datapath.
- Read ports 1/2 supply the ALU's A/B operands; the write port takes the ALU result (res) and overflow flag at writeback.
- Register 0 is hardwired to zero.
- Writes that produced a signed overflow are suppressed and raise a sticky overflow trap. The trap freezes architectural state until software-side control clears it.

---
 rtl/reg_file_wb.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - writeback register file with overflow-suppressed writes and sticky trap
module reg_file_wb #(
    parameter int wordLen = 32,
    parameter int addrLen = 5,
    parameter int bypass  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [addrLen-1:0] ra1,
    input  logic [addrLen-1:0] ra2,
    output logic [wordLen-1:0] rd1,
    output logic [wordLen-1:0] rd2,
    input  logic               we,
    input  logic [addrLen-1:0] wa,
    input  logic [wordLen-1:0] wd,
    input  logic               wovf,
    input  logic               ovfClr,
    output logic               ovfTrap,
    output logic [addrLen-1:0] ovfAddr
);

    localparam int NumRegs = 2 ** addrLen;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [addrLen-1:0] addr_q, addr_d;
    logic [wordLen-1:0] regs_q [NumRegs];
    logic [wordLen-1:0] regs_d [NumRegs];

    logic commit;
    logic trap_set;

    // wovf only matters when a write is actually requested
    assign commit   = we & ~wovf & (state_q == RUN) & (wa != '0);
    assign trap_set = we & wovf & (state_q == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            addr_q  <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (trap_set) state_d = TRAP;
            TRAP:    if (ovfClr)   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (trap_set) addr_d = wa;
    end

    always_comb begin
        regs_d = regs_q;
        if (commit) regs_d[wa] = wd;
    end

    always_comb begin
        ovfTrap = (state_q == TRAP);
        ovfAddr = addr_q;
    end

    always_comb begin
        rd1 = regs_q[ra1];
        if ((bypass != 0) && commit && (ra1 == wa)) rd1 = wd;
        if (ra1 == '0) rd1 = '0;
    end

    always_comb begin
        rd2 = regs_q[ra2];
        if ((bypass != 0) && commit && (ra2 == wa)) rd2 = wd;
        if (ra2 == '0) rd2 = '0;
    end

endmodule
